// File: rtl/dac_word_unpack_16.sv
// Unpacks 32-bit host FIFO words into a 16-bit sample stream, with one-word prefetch.
// Optional macro UNPACK_SWAP_EN: emit the upper half-word first instead of the lower.
module dac_word_unpack_16 #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic             fifo_empty,
   output logic             fifo_rd_en,
   input  logic [31:0]      fifo_dout,
   output logic [15:0]      sample_data,
   output logic             sample_valid,
   input  logic             sample_ready,
   output logic             underrun,
   input  logic             underrun_clr,
   output logic [CNT_W-1:0] sample_count
);

   logic [31:0] act;
   logic [31:0] pf;
   logic        act_v;
   logic        pf_v;
   logic        hsel;
   logic        rd_pend;
   logic        primed;
   logic        hs;
   logic        vacate;
   logic [1:0]  occ;

   assign hs     = act_v & sample_ready;
   assign vacate = hs & hsel;

   // Slot occupancy after this cycle's second-half handshake frees the active word.
   assign occ = {1'b0, act_v} + {1'b0, pf_v} + {1'b0, rd_pend} - {1'b0, vacate};

   assign fifo_rd_en   = ~rst & enable & ~fifo_empty & (occ < 2'd2);
   assign sample_valid = act_v;

`ifdef UNPACK_SWAP_EN
   assign sample_data = hsel ? act[15:0] : act[31:16];
`else
   assign sample_data = hsel ? act[31:16] : act[15:0];
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         act     <= '0;
         pf      <= '0;
         act_v   <= 1'b0;
         pf_v    <= 1'b0;
         hsel    <= 1'b0;
         rd_pend <= 1'b0;
      end else begin
         rd_pend <= fifo_rd_en;
         if (vacate) begin
            hsel <= 1'b0;
            if (pf_v) begin
               act  <= pf;
               pf   <= fifo_dout;
               pf_v <= rd_pend;
            end else if (rd_pend) begin
               act <= fifo_dout;
            end else begin
               act_v <= 1'b0;
            end
         end else begin
            if (hs) begin
               hsel <= 1'b1;
            end
            // Landing data goes to the active slot only when it is empty.
            if (rd_pend) begin
               if (!act_v) begin
                  act   <= fifo_dout;
                  act_v <= 1'b1;
                  hsel  <= 1'b0;
               end else begin
                  pf   <= fifo_dout;
                  pf_v <= 1'b1;
               end
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         primed       <= 1'b0;
         underrun     <= 1'b0;
         sample_count <= '0;
      end else begin
         if (!enable) begin
            primed <= 1'b0;
         end else if (hs) begin
            primed <= 1'b1;
         end
         // A starvation event in the same cycle as a clear keeps the flag set.
         if (enable & primed & sample_ready & ~act_v) begin
            underrun <= 1'b1;
         end else if (underrun_clr) begin
            underrun <= 1'b0;
         end
         if (hs) begin
            sample_count <= sample_count + {{(CNT_W-1){1'b0}}, 1'b1};
         end
      end
   end

endmodule

// File: tb/tb_dac_word_unpack_16.sv
// Testbench for dac_word_unpack_16: directed scenarios plus randomized traffic
// against a queue-based model of the FIFO and the expected sample stream.
module tb_dac_word_unpack_16;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        enable = 1'b0;
   logic        fifo_empty = 1'b1;
   logic        sample_ready = 1'b0;
   logic        underrun_clr = 1'b0;
   logic [31:0] fifo_dout = '0;
   logic        fifo_rd_en;
   logic [15:0] sample_data;
   logic        sample_valid;
   logic        underrun;
   logic [31:0] sample_count;

   dac_word_unpack_16 #(.CNT_W(32)) dut (
      .clk          (clk),
      .rst          (rst),
      .enable       (enable),
      .fifo_empty   (fifo_empty),
      .fifo_rd_en   (fifo_rd_en),
      .fifo_dout    (fifo_dout),
      .sample_data  (sample_data),
      .sample_valid (sample_valid),
      .sample_ready (sample_ready),
      .underrun     (underrun),
      .underrun_clr (underrun_clr),
      .sample_count (sample_count)
   );

   always #5 clk = ~clk;

   int          nCompared = 0;
   int          nMismatched = 0;
   logic [31:0] fifoQ[$];
   logic [15:0] expQ[$];
   logic [31:0] expCount;
   bit          expPrimed;
   bit          expUnderrun;
   int          pops;
   logic        obsRd, obsValid, obsUnderrun, obsHs;
   logic [15:0] obsData;
   logic [31:0] obsCount;
   logic [15:0] exp4 [4];

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      nCompared++;
      assert (obs === expv) else begin
         nMismatched++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic pushWord(input logic [31:0] w);
      fifoQ.push_back(w);
      fifo_empty = 1'b0;
   endtask

   // One clock: sample at the falling edge, then advance the FIFO and stream models.
   task automatic applyStimulus();
      logic        en, rdy, clr;
      logic [31:0] w;
      @(negedge clk);
      obsRd       = fifo_rd_en;
      obsValid    = sample_valid;
      obsData     = sample_data;
      obsUnderrun = underrun;
      obsCount    = sample_count;
      obsHs       = sample_valid & sample_ready;
      en  = enable;
      rdy = sample_ready;
      clr = underrun_clr;
      checkOutput("rd_while_empty", 32'(obsRd & fifo_empty), 32'd0);
      checkOutput("sample_count", obsCount, expCount);
      checkOutput("underrun", 32'(obsUnderrun), 32'(expUnderrun));
      if (obsValid) begin
         checkOutput("sample_expected", 32'(expQ.size() != 0), 32'd1);
         if (expQ.size() != 0) checkOutput("sample_data", 32'(obsData), 32'(expQ[0]));
      end
      @(posedge clk);
      #1;
      if (obsHs) begin
         if (expQ.size() != 0) void'(expQ.pop_front());
         expCount = expCount + 32'd1;
      end
      if (en && expPrimed && rdy && !obsValid) expUnderrun = 1'b1;
      else if (clr) expUnderrun = 1'b0;
      if (!en) expPrimed = 1'b0;
      else if (obsHs) expPrimed = 1'b1;
      if (obsRd && fifoQ.size() != 0) begin
         w = fifoQ.pop_front();
         fifo_dout = w;
         pops++;
`ifdef UNPACK_SWAP_EN
         expQ.push_back(w[31:16]);
         expQ.push_back(w[15:0]);
`else
         expQ.push_back(w[15:0]);
         expQ.push_back(w[31:16]);
`endif
      end else begin
         fifo_dout = $urandom;
      end
      fifo_empty = (fifoQ.size() == 0);
   endtask

   task automatic doReset();
      #2;
      rst = 1'b1;
      #1;
      checkOutput("rst_rd_en", 32'(fifo_rd_en), 32'd0);
      checkOutput("rst_valid", 32'(sample_valid), 32'd0);
      checkOutput("rst_data", 32'(sample_data), 32'd0);
      checkOutput("rst_underrun", 32'(underrun), 32'd0);
      checkOutput("rst_count", sample_count, 32'd0);
      fifoQ.delete();
      expQ.delete();
      expCount    = '0;
      expPrimed   = 1'b0;
      expUnderrun = 1'b0;
      pops        = 0;
      fifo_empty  = 1'b1;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic drain(input int budget);
      int k = 0;
      while ((expQ.size() != 0 || fifoQ.size() != 0 || obsValid) && k < budget) begin
         applyStimulus();
         k++;
      end
      checkOutput("drain_done", 32'(expQ.size()), 32'd0);
   endtask

   initial begin
`ifdef UNPACK_SWAP_EN
      exp4[0] = 16'h2222; exp4[1] = 16'h1111; exp4[2] = 16'h4444; exp4[3] = 16'h3333;
`else
      exp4[0] = 16'h1111; exp4[1] = 16'h2222; exp4[2] = 16'h3333; exp4[3] = 16'h4444;
`endif
      obsValid = 1'b0;
      doReset();

      $display("[TB] steady stream and latency");
      pushWord(32'h22221111);
      pushWord(32'h44443333);
      enable = 1'b1;
      sample_ready = 1'b1;
      applyStimulus();
      checkOutput("lat_rd_cycle0", 32'(obsRd), 32'd1);
      checkOutput("lat_valid_cycle0", 32'(obsValid), 32'd0);
      applyStimulus();
      checkOutput("lat_valid_cycle1", 32'(obsValid), 32'd0);
      for (int i = 0; i < 4; i++) begin
         applyStimulus();
         checkOutput("stream_valid", 32'(obsValid), 32'd1);
         checkOutput("stream_data", 32'(obsData), 32'(exp4[i]));
      end
      applyStimulus();
      checkOutput("stream_end_valid", 32'(obsValid), 32'd0);
      checkOutput("stream_count", obsCount, 32'd4);
      doReset();

      $display("[TB] throughput");
      for (int i = 0; i < 20; i++) pushWord($urandom);
      enable = 1'b1;
      sample_ready = 1'b1;
      applyStimulus();
      applyStimulus();
      for (int i = 0; i < 40; i++) begin
         applyStimulus();
         checkOutput("no_bubble", 32'(obsValid), 32'd1);
      end
      enable = 1'b0;
      drain(20);
      doReset();

      $display("[TB] backpressure");
      pushWord(32'h22221111);
      for (int i = 0; i < 3; i++) pushWord($urandom);
      enable = 1'b1;
      sample_ready = 1'b0;
      for (int i = 0; i < 3; i++) applyStimulus();
      for (int i = 0; i < 5; i++) begin
         applyStimulus();
         checkOutput("bp_valid", 32'(obsValid), 32'd1);
         checkOutput("bp_hold", 32'(obsData), 32'(exp4[0]));
      end
      checkOutput("bp_reads", 32'(pops <= 2), 32'd1);
      sample_ready = 1'b1;
      drain(60);
      checkOutput("bp_count", sample_count, 32'd8);
      doReset();

      $display("[TB] underrun");
      pushWord(32'h22221111);
      enable = 1'b1;
      sample_ready = 1'b1;
      for (int i = 0; i < 4; i++) applyStimulus();
      applyStimulus();
      checkOutput("ur_valid_drop", 32'(obsValid), 32'd0);
      checkOutput("ur_not_yet", 32'(obsUnderrun), 32'd0);
      applyStimulus();
      checkOutput("ur_set", 32'(obsUnderrun), 32'd1);
      sample_ready = 1'b0;
      underrun_clr = 1'b1;
      applyStimulus();
      underrun_clr = 1'b0;
      applyStimulus();
      checkOutput("ur_cleared", 32'(obsUnderrun), 32'd0);
      sample_ready = 1'b1;
      underrun_clr = 1'b1;
      applyStimulus();
      underrun_clr = 1'b0;
      sample_ready = 1'b0;
      applyStimulus();
      checkOutput("ur_set_wins", 32'(obsUnderrun), 32'd1);
      doReset();

      $display("[TB] enable drop mid-word");
      pushWord(32'h22221111);
      pushWord(32'h44443333);
      pushWord(32'h66665555);
      enable = 1'b1;
      sample_ready = 1'b1;
      for (int i = 0; i < 3; i++) applyStimulus();
      checkOutput("ed_first_hs", 32'(obsHs), 32'd1);
      checkOutput("ed_first_data", 32'(obsData), 32'(exp4[0]));
      enable = 1'b0;
      for (int i = 0; i < 10; i++) begin
         applyStimulus();
         checkOutput("ed_no_read", 32'(obsRd), 32'd0);
      end
      checkOutput("ed_all_delivered", 32'(expQ.size()), 32'd0);
      checkOutput("ed_word_left", 32'(fifoQ.size()), 32'd1);
      checkOutput("ed_count", sample_count, 32'd4);
      doReset();

      $display("[TB] reset with read in flight");
      pushWord(32'h22221111);
      pushWord(32'h44443333);
      enable = 1'b1;
      sample_ready = 1'b1;
      applyStimulus();
      checkOutput("rf_read_issued", 32'(obsRd), 32'd1);
      doReset();
      enable = 1'b0;
      for (int i = 0; i < 6; i++) begin
         applyStimulus();
         checkOutput("rf_no_emit", 32'(obsValid), 32'd0);
      end

      $display("[TB] randomized traffic");
      doReset();
      enable = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 3) != 0 && fifoQ.size() < 16) pushWord($urandom);
         sample_ready = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 63) == 0) enable = ~enable;
         underrun_clr = ($urandom_range(0, 15) == 0);
         applyStimulus();
      end
      enable = 1'b0;
      sample_ready = 1'b1;
      underrun_clr = 1'b0;
      fifoQ.delete();
      fifo_empty = 1'b1;
      drain(40);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule

// File: doc/dac_word_unpack_16.md
# dac_word_unpack_16

Host-to-FPGA sample unpacker for the playback path. Pulls 32-bit words from the Xillybus host-to-FPGA FIFO read port and emits them as a stream of 16-bit samples, two per word, with a valid/ready handshake toward the DAC interface. Undoes the half-word swap the capture path applies, so host buffers round-trip unchanged. Sustains one sample per clock with a one-word prefetch.

## Interface
- `CNT_W`, default 32: width of the delivered-sample counter.
- `clk` input 1: single clock for FIFO read side and sample output.
- `rst` input 1: asynchronous, active-high reset.
- `enable` input 1: 1 = fetch words from the FIFO; 0 = stop issuing reads, already-buffered samples still drain.
- `fifo_empty` input 1: FIFO empty flag (standard, non-FWFT FIFO).
- `fifo_rd_en` output 1: FIFO read strobe; data appears on `fifo_dout` the following cycle.
- `fifo_dout` input 32: FIFO read data.
- `sample_data` output 16: current sample.
- `sample_valid` output 1: `sample_data` is valid.
- `sample_ready` input 1: consumer accepts the sample this cycle.
- `underrun` output 1: sticky; the stream starved while running.
- `underrun_clr` input 1: synchronous clear of `underrun`.
- `sample_count` output CNT_W: samples delivered since reset.

## Operation
- Storage: active word register (`act`, with valid flag and half-select bit `hsel`), prefetch word register (`pf`, with valid flag), and an in-flight flag `rd_pend` (read issued, data arriving next cycle).
- Read issue: `fifo_rd_en = enable & ~fifo_empty & (act_v + pf_v + rd_pend < 2)`, where the occupancy count accounts for slots freed this cycle by a second-half handshake. Never read while `fifo_empty = 1`.
- Data landing: when `rd_pend` is set, `fifo_dout` is written into `act` if `act` is empty or being vacated this cycle, and into `pf` otherwise.
- Output: `sample_valid = act_v`. `sample_data = act[15:0]` when `hsel = 0`, and `act[31:16]` when `hsel = 1`.
- Handshake (`sample_valid & sample_ready`):
  - `hsel = 0`: `hsel` becomes 1.
  - `hsel = 1`: `hsel` becomes 0 and `act` is refilled from `pf` if `pf_v`, else from landing data, else `act_v` becomes 0.
- `sample_data` must hold stable while `sample_valid = 1` and `sample_ready = 0`.
- `sample_count` increments by 1 on each handshake and wraps modulo 2^CNT_W.
- Underrun:
  - An internal `primed` bit sets on the first handshake after `enable` rises and clears when `enable = 0`.
  - `underrun` sets when `enable & primed & sample_ready & ~sample_valid`.
  - `underrun_clr` clears it. If set and clear occur in the same cycle, set wins.
- Deasserting `enable` mid-word still delivers the buffered halves and any in-flight word. No partial word is discarded.

## Timing
- Reset values: `fifo_rd_en` = 0, `sample_valid` = 0, `sample_data` = 0, `underrun` = 0, `sample_count` = 0. `act_v`, `pf_v`, `rd_pend`, `hsel` and `primed` all reset to 0.
- `rst` asserted mid-stream discards all buffered and in-flight data. A read completing after reset release is ignored, because `rd_pend` was cleared.
- Latency: `fifo_rd_en` asserts in the cycle `enable & ~fifo_empty` is first seen with buffers empty (cycle 0). Data lands in cycle 1. `sample_valid` is high in cycle 2.
- Throughput: with a non-empty FIFO and `sample_ready` held at 1, one sample per cycle and no bubbles. `fifo_rd_en` is high on alternate cycles in steady state.
- `fifo_rd_en` is registered-input combinational only from `fifo_empty` and `enable` plus internal state. There is no path from `fifo_dout`.

## Configuration
- `UNPACK_SWAP_EN`:
  - Defined: the first-emitted sample is `act[31:16]` and the second is `act[15:0]`, for hosts writing native order without the capture-path swap.
  - Undefined (default): the first sample is `act[15:0]` and the second is `act[31:16]`.

## Test plan
- Reset then steady stream: FIFO holds 0x22221111 and 0x44443333, `enable=1`, `sample_ready=1` → samples 0x1111, 0x2222, 0x3333, 0x4444 on four consecutive cycles. First `sample_valid` is 2 cycles after the first `fifo_rd_en`. `sample_count` = 4.
- Backpressure: `sample_ready` low for 5 cycles while holding 0x1111 → `sample_data` stays stable, at most 2 words are read from the FIFO, and no sample is lost or duplicated.
- Underrun: the FIFO empties after one word with `sample_ready=1` → `underrun` sets 1 cycle after `sample_valid` drops. `underrun_clr` pulse → 0. Simultaneous set and clear → stays 1.
- Enable drop mid-word: `enable=0` right after 0x1111 is accepted → 0x2222 plus the in-flight word still delivered. No `fifo_rd_en` afterwards.
- Async reset mid-stream with a read in flight → all outputs go to reset values immediately. The in-flight word is not emitted after release.
- `UNPACK_SWAP_EN` build: word 0x22221111 → samples 0x2222 then 0x1111.
